// File: rtl/sram_1r1w_masked_init.sv
`default_nettype none
// ============================================================================
// Module      : sram_1r1w_masked_init
// Description : One-read/one-write synchronous SRAM model with per-segment
//               write masking, same-edge collision forwarding, a held
//               registered read port and a post-reset initialisation sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1r1w_masked_init #(
    parameter int                    DATA_WIDTH = 50,
    parameter int                    DEPTH      = 512,
    parameter int                    MASK_GRAN  = 50,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter bit                    BYPASS     = 1'b1,
    localparam int                   MASK_SEGS  = DATA_WIDTH / MASK_GRAN,
    localparam int                   ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  ready,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [MASK_SEGS-1:0]  w_mask
);

    // Geometry checks: the mask must tile the word exactly.
    if (DATA_WIDTH % MASK_GRAN != 0) begin : g_bad_mask_gran
        $error("DATA_WIDTH must be a multiple of MASK_GRAN");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("DEPTH must be at least 2");
    end

    // Extended-width depth so non-power-of-two arrays can flag out-of-range
    // addresses with a plain unsigned compare.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  r_in_range;
    logic                  w_in_range;
    logic                  rd_accept;
    logic                  wr_commit;
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;

    assign r_in_range = {1'b0, r_addr} < DEPTH_EXT;
    assign w_in_range = {1'b0, w_addr} < DEPTH_EXT;

    // Requests only count once the sweep has finished.
    assign rd_accept  = ready & r_en;
    assign wr_commit  = ready & w_en & w_in_range;
    assign collide    = wr_commit & (w_addr == r_addr);

    assign rd_old     = mem[r_addr];
    assign wr_old     = mem[w_addr];

    // Merged word: masked-in segments from w_data, the rest from the array.
    // The same word is both what gets written and what a write-first
    // collision forwards to the read port.
    for (genvar i = 0; i < MASK_SEGS; i++) begin : g_seg
        assign wr_merged[i*MASK_GRAN +: MASK_GRAN] =
            w_mask[i] ? w_data[i*MASK_GRAN +: MASK_GRAN]
                      : wr_old[i*MASK_GRAN +: MASK_GRAN];
    end

    // Init sweep / run control: walk every entry once, then raise ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Registered read port: captured only on an accepted read, held otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= rd_accept;
            if (rd_accept) begin
                if (!r_in_range) begin
                    r_data <= '0;
                end else if (BYPASS && collide) begin
                    r_data <= wr_merged;
                end else begin
                    r_data <= rd_old;
                end
            end
        end
    end

    // Array storage: no reset. While reset is held the sweep pointer sits at
    // entry 0 and keeps rewriting INIT_VALUE there, which the sweep would do
    // on the first released edge anyway.
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= INIT_VALUE;
        end else if (wr_commit) begin
            mem[w_addr] <= wr_merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_masked_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_1r1w_masked_init
// Description : Scoreboard bench for sram_1r1w_masked_init. Two instances
//               share one stimulus stream: DEPTH=8 write-first and DEPTH=6
//               (non-power-of-two) read-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_1r1w_masked_init;

    localparam int             DW   = 16;
    localparam int             MG   = 4;
    localparam int             SEGS = DW / MG;
    localparam int             AW   = 3;
    localparam logic [DW-1:0]  INIT = 16'h0155;

    logic            clock   = 1'b0;
    logic            reset_n = 1'b1;
    logic            r_en    = 1'b0;
    logic            w_en    = 1'b0;
    logic [AW-1:0]   r_addr  = '0;
    logic [AW-1:0]   w_addr  = '0;
    logic [DW-1:0]   w_data  = '0;
    logic [SEGS-1:0] w_mask  = '0;

    logic            ready0, ready1, r_valid0, r_valid1;
    logic [DW-1:0]   r_data0, r_data1;

    always #5 clock = ~clock;

    sram_1r1w_masked_init #(
        .DATA_WIDTH(DW), .DEPTH(8), .MASK_GRAN(MG), .INIT_VALUE(INIT), .BYPASS(1'b1)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .ready(ready0),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data0), .r_valid(r_valid0),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask)
    );

    sram_1r1w_masked_init #(
        .DATA_WIDTH(DW), .DEPTH(6), .MASK_GRAN(MG), .INIT_VALUE(INIT), .BYPASS(1'b0)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .ready(ready1),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data1), .r_valid(r_valid1),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask)
    );

    logic          rdy_v [2];
    logic          val_v [2];
    logic [DW-1:0] dat_v [2];
    assign rdy_v[0] = ready0;   assign rdy_v[1] = ready1;
    assign val_v[0] = r_valid0; assign val_v[1] = r_valid1;
    assign dat_v[0] = r_data0;  assign dat_v[1] = r_data1;

    // Reference model
    int            depth_of  [2] = '{8, 6};
    bit            bypass_of [2] = '{1'b1, 1'b0};
    logic [DW-1:0] mdl       [2][8];
    logic [DW-1:0] last_data [2];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int            edges_done = 0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [SEGS-1:0] m);
        logic [DW-1:0] res;
        res = old;
        for (int i = 0; i < SEGS; i++)
            if (m[i]) res[i*MG +: MG] = nw[i*MG +: MG];
        return res;
    endfunction

    // One clock of stimulus; expected read results are queued after the edge.
    task automatic cycle(input logic re, input int ra, input logic we, input int wa,
                         input logic [DW-1:0] wd, input logic [SEGS-1:0] wm);
        logic [DW-1:0] e [2];
        bit            pend [2];
        r_en = re; r_addr = ra[AW-1:0];
        w_en = we; w_addr = wa[AW-1:0]; w_data = wd; w_mask = wm;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0;
            e[k]    = '0;
            if (reset_n && edges_done >= depth_of[k]) begin
                if (re) begin
                    pend[k] = 1'b1;
                    if (ra >= depth_of[k])
                        e[k] = '0;
                    else if (we && wa == ra && bypass_of[k])
                        e[k] = merge(mdl[k][ra], wd, wm);
                    else
                        e[k] = mdl[k][ra];
                end
                if (we && wa < depth_of[k])
                    mdl[k][wa] = merge(mdl[k][wa], wd, wm);
            end
        end
        @(posedge clock);
        #1;
        if (reset_n) edges_done++;
        if (pend[0]) exp_q0.push_back(e[0]);
        if (pend[1]) exp_q1.push_back(e[1]);
        r_en = 1'b0; w_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0, '0, '0);
    endtask

    // Assert reset asynchronously, check outputs clear at once, release.
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (rdy_v[k] !== 1'b0 || val_v[k] !== 1'b0 || dat_v[k] !== '0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: ready=%b r_valid=%b r_data=%h, required 0/0/0000",
                         k, rdy_v[k], val_v[k], dat_v[k]);
            end
        end
        exp_q0.delete();
        exp_q1.delete();
        last_data[0] = '0;
        last_data[1] = '0;
        edges_done   = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) mdl[k][i] = INIT;
    endtask

    // Monitor: ready level, popped read results, and hold behaviour.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            logic          exp_rdy;
            logic [DW-1:0] e;
            int            qn;
            exp_rdy = reset_n && (edges_done >= depth_of[k]);
            n_checks++;
            if (rdy_v[k] !== exp_rdy) begin
                n_fail++;
                $display("FAIL ready dut%0d edge %0d: got %b, required %b", k, edges_done, rdy_v[k], exp_rdy);
            end
            qn = (k == 0) ? exp_q0.size() : exp_q1.size();
            n_checks++;
            if (val_v[k] === 1'b1) begin
                if (qn == 0) begin
                    n_fail++;
                    $display("FAIL spurious_r_valid dut%0d: r_valid=1 r_data=%h, required r_valid=0", k, dat_v[k]);
                end else begin
                    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    last_data[k] = e;
                    if (dat_v[k] !== e) begin
                        n_fail++;
                        $display("FAIL read_data dut%0d: got %h, required %h", k, dat_v[k], e);
                    end
                end
            end else if (qn != 0) begin
                n_fail++;
                $display("FAIL missing_r_valid dut%0d: r_valid=%b, required 1", k, val_v[k]);
                if (k == 0) exp_q0.delete(); else exp_q1.delete();
            end else if (val_v[k] !== 1'b0 || dat_v[k] !== last_data[k]) begin
                n_fail++;
                $display("FAIL hold dut%0d: r_valid=%b r_data=%h, required 0/%h", k, val_v[k], dat_v[k], last_data[k]);
            end
        end
    end

    initial begin
        logic [DW-1:0] rd;
        #1;
        do_reset();

        // Init sweep with r_en held high: nothing accepted until ready.
        for (int i = 0; i < 9; i++) cycle(1'b1, i % 8, 1'b0, 0, '0, '0);
        idle(1);
        for (int i = 0; i < 8; i++) cycle(1'b1, i, 1'b0, 0, '0, '0);
        idle(2);

        // Masked write then read back.
        cycle(1'b0, 0, 1'b1, 3, 16'hFFFF, 4'hF);
        cycle(1'b0, 0, 1'b1, 3, 16'h1234, 4'b0101);
        cycle(1'b1, 3, 1'b0, 0, '0, '0);
        idle(1);

        // Collision on address 5, then a follow-up read.
        cycle(1'b0, 0, 1'b1, 5, 16'hAAAA, 4'hF);
        cycle(1'b1, 5, 1'b1, 5, 16'h5555, 4'b0011);
        cycle(1'b1, 5, 1'b0, 0, '0, '0);
        idle(1);

        // Streaming reads then a long idle to exercise the hold.
        cycle(1'b1, 1, 1'b0, 0, '0, '0);
        cycle(1'b1, 2, 1'b0, 0, '0, '0);
        cycle(1'b1, 3, 1'b0, 0, '0, '0);
        idle(5);

        // Zero-mask write, out-of-range write/read, write-then-read.
        cycle(1'b0, 0, 1'b1, 2, 16'hDEAD, 4'h0);
        cycle(1'b0, 0, 1'b1, 7, 16'hBEEF, 4'hF);
        cycle(1'b1, 7, 1'b1, 6, 16'hC0DE, 4'hF);
        cycle(1'b1, 6, 1'b0, 0, '0, '0);
        cycle(1'b1, 2, 1'b0, 0, '0, '0);

        // Randomised traffic with frequent collisions.
        for (int i = 0; i < 400; i++) begin
            int ra, wa;
            ra = $urandom_range(0, 7);
            wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 7);
            rd = DW'($urandom);
            cycle(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                  rd, SEGS'($urandom));
        end

        // Reset during RUN with a read result in flight.
        for (int i = 0; i < 8; i++) cycle(1'b0, 0, 1'b1, i, 16'h0F0F ^ DW'(i), 4'hF);
        cycle(1'b1, 4, 1'b0, 0, '0, '0);
        do_reset();

        // Reset again mid-sweep (init_cnt = 4), then full sweep.
        idle(4);
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, i % 8, 1'b0, 0, '0, '0);
        for (int i = 0; i < 8; i++) cycle(1'b1, i, 1'b0, 0, '0, '0);
        idle(3);

        n_checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d results outstanding, required 0/0", exp_q0.size(), exp_q1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_1r1w_masked_init.md
# sram_1r1w_masked_init

Parametrised one-read/one-write synchronous SRAM model for the next generation of array wrappers. It replaces fixed-geometry arrays with a single block configurable in depth, width and write-mask granularity. It adds sub-word write masking, same-cycle read/write collision forwarding, a held registered read output, and a self-clearing initialisation sweep after reset.

## Interface
- DATA_WIDTH, 50, data bits per entry
- DEPTH, 512, number of entries (any value ≥ 2)
- MASK_GRAN, 50, bits per write-mask segment; DATA_WIDTH % MASK_GRAN == 0 is required, otherwise elaboration error
- MASK_SEGS, DATA_WIDTH/MASK_GRAN, derived, not overridable
- ADDR_WIDTH, $clog2(DEPTH), derived
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every entry by the init sweep
- BYPASS, 1, 1 = write-first on collision, 0 = read-first

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- ready  out  1  high once the init sweep is complete; requests are accepted only while high
- r_en  in  1  read request
- r_addr  in  ADDR_WIDTH  read address
- r_data  out  DATA_WIDTH  registered read data, held between reads
- r_valid  out  1  one-cycle pulse, r_data updated this cycle
- w_en  in  1  write request
- w_addr  in  ADDR_WIDTH  write address
- w_data  in  DATA_WIDTH  write data
- w_mask  in  MASK_SEGS  per-segment write enable; bit i covers data[i*MASK_GRAN +: MASK_GRAN]

## Operation
- State machine with two states.
  - INIT (reset state): counter init_cnt starts at 0. Each edge writes INIT_VALUE to entry init_cnt, then increments it. On the edge that writes DEPTH-1, the state moves to RUN.
  - RUN: normal operation. RUN is left only by reset.
- ready is a register: 0 in INIT, 1 in RUN.
- While ready=0, r_en and w_en are ignored. No array write occurs, r_valid stays 0, and r_data is unchanged.
- Write (RUN, w_en=1): for each i with w_mask[i]=1, segment i of entry w_addr takes w_data segment i. Other segments are unchanged. w_mask all-zero writes nothing.
- Read (RUN, r_en=1): on the edge, r_data captures the entry at r_addr and r_valid is set to 1 for the following cycle.
  - With r_en=0, r_valid goes to 0 and r_data holds its last value. Never garbage, never re-sampled.
- Collision (r_en & w_en, r_addr==w_addr, same edge):
  - BYPASS=1: each r_data segment equals w_data where w_mask is set, else the old array contents.
  - BYPASS=0: r_data equals the old contents.
  - The array is written in both cases.
- Out-of-range addresses (≥ DEPTH, non-power-of-two DEPTH):
  - A write is dropped.
  - A read returns all zeros with r_valid=1.
- Reset asserted at any time, including mid-sweep or mid-operation:
  - Immediately sets state=INIT, init_cnt=0, ready=0, r_valid=0, r_data=0.
  - The sweep restarts from entry 0 after release.
  - Array contents are not cleared asynchronously; only the sweep clears them.

## Timing
- Reset values: ready=0, r_valid=0, r_data=0.
- Init: the first rising edge with reset_n=1 writes entry 0. After edge number DEPTH, ready=1. A request is first accepted on edge DEPTH+1.
- Read latency: 1 cycle. Request sampled at edge N; r_data/r_valid are valid after edge N, in cycle N+1.
- Back-to-back reads every cycle are supported, giving one result per cycle.
- Write-then-read of the same address on consecutive edges returns the new data, independent of BYPASS.
- Throughput: one read and one write per cycle, to any addresses.

## Test plan
- **Init sweep** (DEPTH=8, INIT_VALUE=0x155): release reset.
  - ready is 0 for 8 edges, then 1.
  - Reads of addresses 0..7 all return 0x155, with r_valid pulsing one cycle after each r_en.
  - r_en held high during INIT yields no r_valid.
- **Masked write** (DATA_WIDTH=16, MASK_GRAN=4): write 0xFFFF to address 3 with mask 0xF, then 0x1234 with mask 0b0101. Read of address 3 returns 0xF2F4.
- **Collision, BYPASS=1**: address 5 holds 0xAAAA. Same-edge read and write of address 5 with data 0x5555, mask 0b0011. r_data=0xAA55, and a later read returns 0xAA55.
- **Collision, BYPASS=0**: same stimulus as above. r_data=0xAAAA, and the following read returns 0xAA55.
- **Hold and streaming**:
  - Read addresses 1, 2, 3 on consecutive edges; r_data follows one cycle later with r_valid high 3 cycles.
  - Idle 5 cycles: r_data stays the value from address 3 and r_valid=0.
- **Mid-sweep reset**: assert reset_n=0 at init_cnt=4 (DEPTH=8).
  - Outputs go to 0 asynchronously.
  - After release, ready rises exactly 8 edges later.
  - Entries written in RUN before the reset read back INIT_VALUE.
